// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared types and helpers for the serial parity receive path:
//               receiver state encoding, EVEN/ODD parity constants and the
//               bit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

  // Receiver framing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Running-parity register values
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Smallest w such that 2**w >= value (value in 1..64 is enough here)
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 7; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_accum.sv
`default_nettype none
// ============================================================================
// Module      : parity_accum
// Description : One-bit running EVEN/ODD parity register. A load overrides a
//               toggle; asynchronous active-low reset returns it to EVEN.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_accum
  import parity_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_val,
  input  logic toggle,
  output logic p
);

  // Parity state: load a fresh value or flip on each received 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= EVEN;
    end else if (load) begin
      p <= load_val;
    end else if (toggle) begin
      p <= ~p;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_checker
// Description : Deserializes LSB-first frames of DATA_W data bits plus one
//               parity bit, presents each completed word with a parity-error
//               flag and flags aborted partial frames.
//               Optional macro PARITY_CHK_ERR_CNT_EN adds a saturating 8-bit
//               parity-error counter on port err_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              frame_start,
  input  logic              x,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_drop,
  output logic              busy
`ifdef PARITY_CHK_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int               CNT_W    = clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] bit_vec;
  logic              p_run;
  logic              start;
  logic              shift;
  logic              complete;
  logic              abort;
  logic              parity_bad;

  // Running parity of the data bits seen so far in this frame
  parity_accum u_parity_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .load_val (x),
    .toggle   (shift & x),
    .p        (p_run)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Decode the valid bit into a frame action and pick the next state
  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    if (bit_valid) begin
      case (state)
        IDLE: begin
          start = frame_start;
        end
        DATA: begin
          if (frame_start) begin
            start = 1'b1;
            abort = 1'b1;
          end else begin
            shift = 1'b1;
          end
        end
        PARITY: begin
          if (frame_start) begin
            start = 1'b1;
            abort = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
        default: begin
          start = 1'b0;
        end
      endcase
    end
    if (start) begin
      state_next = (DATA_W == 1) ? PARITY : DATA;
    end else if (shift && (cnt == LAST_IDX)) begin
      state_next = PARITY;
    end else if (complete) begin
      state_next = IDLE;
    end
  end

  // Incoming bit placed at position 0, shifted to its slot by cnt
  always_comb begin
    bit_vec    = '0;
    bit_vec[0] = x;
  end

  assign parity_bad = ((p_run ^ x) != ODD_PARITY);
  assign busy       = (state != IDLE);

  // Shift register, bit counter and registered frame results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      cnt        <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      out_valid  <= complete;
      frame_drop <= abort;
      if (start) begin
        shreg <= bit_vec;
        cnt   <= ONE;
      end else if (shift) begin
        shreg <= shreg | (bit_vec << cnt);
        cnt   <= cnt + ONE;
      end else if (complete) begin
        cnt   <= '0;
      end
      if (complete) begin
        data_out   <= shreg;
        parity_err <= parity_bad;
      end
    end
  end

`ifdef PARITY_CHK_ERR_CNT_EN
  // Saturating count of completed frames with a parity error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (complete && parity_bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receive end of the serial parity link. Deserializes LSB-first frames of DATA_W data bits followed by one parity bit, and tracks running parity with a two-state even/odd FSM. Each completed frame is presented as a parallel word with a parity-error flag. Sits after the serial bit source, in front of any word-level consumer.

## Interface
- DATA_W, default 8: data bits per frame, legal range 1..32.
- ODD_PARITY, default 0: 0 selects even parity (data plus parity bit has an even count of 1s); 1 selects odd parity.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_valid  in  1  x carries a bit this cycle.
- frame_start  in  1  qualified by bit_valid; marks x as data bit 0 of a new frame.
- x  in  1  serial data.
- data_out  out  DATA_W  last completed word, bit 0 = first received.
- out_valid  out  1  one-cycle pulse: frame complete.
- parity_err  out  1  parity result of the last completed frame.
- frame_drop  out  1  one-cycle pulse: a partial frame was aborted.
- busy  out  1  high when the state is not IDLE.

## Operation
- States: IDLE, DATA, PARITY. Parity register P has values EVEN (0) and ODD (1).
- Cycles with bit_valid=0 change nothing: no state, counter, or P update.
- IDLE
  - bit_valid and frame_start: load shift bit 0 with x, set P=x, set cnt=1.
  - Next state is DATA, or PARITY when DATA_W==1.
  - bit_valid without frame_start is ignored.
- DATA
  - bit_valid: shift x into position cnt, P ^= x, cnt++.
  - Once DATA_W bits have been received, next state is PARITY.
- PARITY
  - bit_valid (without frame_start): p=x.
  - parity_err = (P ^ p) != ODD_PARITY.
  - Load data_out from the shift register, pulse out_valid, go to IDLE.
- frame_start with bit_valid in DATA or PARITY:
  - Abort the current frame and pulse frame_drop.
  - x becomes bit 0 of the new frame (same loading as IDLE).
  - No out_valid for the aborted frame; data_out and parity_err are unchanged.
- data_out and parity_err hold their values between completions.
- busy is decoded combinationally from the state register.

## Timing
- Reset values: data_out=0, out_valid=0, parity_err=0, frame_drop=0, busy=0, state IDLE, P=EVEN, cnt=0.
- Latency: out_valid, data_out, and parity_err update at the same edge that samples the parity bit. They are visible in the following cycle. out_valid is high for exactly one cycle.
- Back-to-back frames: frame_start is accepted in the cycle immediately after the parity bit. Throughput is one frame per DATA_W+1 valid bits.
- frame_drop is registered and pulses one cycle after the aborting edge.
- Reset mid-frame: immediate return to reset values. The partial frame is lost without a frame_drop pulse.
- Gaps in bit_valid of any length are legal within a frame.

## Configuration
- PARITY_CHK_ERR_CNT_EN defined:
  - Adds output err_cnt [7:0].
  - Increments on each out_valid with parity_err=1 and saturates at 255.
  - Cleared only by rst_n; reset value 0.
- Undefined: the err_cnt port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package parity_pkg holds:
  - the state typedef (IDLE, DATA, PARITY);
  - the EVEN=0 and ODD=1 constants;
  - the counter width function clog2(DATA_W+1).
- Sub-module parity_accum: one-bit EVEN/ODD register with load and toggle enables, async active-low reset to EVEN. The checker instantiates it once for P.

## Test plan
- DATA_W=8, even parity:
  - Frame 0xA5 with parity bit 0 gives data_out=0xA5 and parity_err=0.
  - The same frame with parity bit 1 gives parity_err=1.
  - out_valid pulses once in each case.
- Frame 0x3C with random bit_valid gaps of 0–5 cycles: data_out=0x3C, parity_err=0, busy high from the first bit until the completion cycle.
- Abort: frame_start after 4 bits of 0xFF, then full frame 0x01 with parity bit 1:
  - one frame_drop pulse;
  - one out_valid with data_out=0x01, parity_err=0.
- Reset mid-frame: rst_n low after 5 bits drops all outputs to 0 asynchronously. A following frame 0x80 with parity bit 1 decodes cleanly.
- ODD_PARITY=1, DATA_W=1: bit 1 with parity bit 0 gives parity_err=0; bit 1 with parity bit 1 gives parity_err=1.
- With PARITY_CHK_ERR_CNT_EN: 260 consecutive bad-parity frames leave err_cnt=255.
